// File: rtl/exe_branch_resolve_pkg.sv
// Shared types and defaults for the EXE branch-resolve block.
// Holds the redirect FSM state encoding and the target-alignment helper.
package exe_branch_resolve_pkg;

    localparam int unsigned ADDR_W_DEF = 40;
    localparam int unsigned TAG_W_DEF  = 4;
    localparam int unsigned CNT_W_DEF  = 32;

    typedef enum logic {
        BR_RES_IDLE = 1'b0,
        BR_RES_REQ  = 1'b1
    } br_res_state_e;

    // Instruction fetch is word granular; low two target bits must be zero.
    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/branch_stat_counter.sv
// Saturating event counter used for branch statistics.
module branch_stat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/exe_branch_resolve.sv
// Compares resolved branch next-PC against the fetch prediction and issues a
// held redirect request to fetch. Optional statistics under BRANCH_STATS_EN.
module exe_branch_resolve
    import exe_branch_resolve_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_result,
    input  logic [ADDR_W-1:0] br_pred_pc,
    input  logic [TAG_W-1:0]  br_tag,
    input  logic              flush_ext,
    input  logic              redirect_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [TAG_W-1:0]  redirect_tag,
    output logic              kill_younger,
    output logic              br_misalign,
    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_mispred
);

    br_res_state_e     state;
    br_res_state_e     state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [TAG_W-1:0]  tag_nxt;
    logic              misalign_nxt;
    logic              mispred_c;

    assign mispred_c = br_valid && (br_result != br_pred_pc);

    // Next-state and capture logic; flush overrides everything.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = redirect_pc;
        tag_nxt      = redirect_tag;
        misalign_nxt = 1'b0;
        if (flush_ext) begin
            state_nxt = BR_RES_IDLE;
        end else begin
            case (state)
                BR_RES_IDLE: begin
                    if (mispred_c) begin
                        tag_nxt = br_tag;
                        if (word_aligned(br_result[1:0])) begin
                            state_nxt = BR_RES_REQ;
                            pc_nxt    = br_result;
                        end else begin
                            misalign_nxt = 1'b1;
                        end
                    end
                end
                BR_RES_REQ: begin
                    if (redirect_ready) begin
                        state_nxt = BR_RES_IDLE;
                    end
                end
                default: state_nxt = BR_RES_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= BR_RES_IDLE;
            redirect_valid <= 1'b0;
            kill_younger   <= 1'b0;
            br_misalign    <= 1'b0;
            redirect_pc    <= '0;
            redirect_tag   <= '0;
        end else begin
            state          <= state_nxt;
            redirect_valid <= (state_nxt == BR_RES_REQ);
            kill_younger   <= (state_nxt == BR_RES_REQ);
            br_misalign    <= misalign_nxt;
            redirect_pc    <= pc_nxt;
            redirect_tag   <= tag_nxt;
        end
    end

`ifdef BRANCH_STATS_EN
    logic br_cnt_inc;
    logic mp_cnt_inc;

    // Branches arriving while a redirect is pending are squashed, not counted.
    assign br_cnt_inc = br_valid  && !flush_ext && (state == BR_RES_IDLE);
    assign mp_cnt_inc = mispred_c && !flush_ext && (state == BR_RES_IDLE);

    branch_stat_counter #(.CNT_W(CNT_W)) u_cnt_branches (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_cnt_inc),
        .count (stat_branches)
    );

    branch_stat_counter #(.CNT_W(CNT_W)) u_cnt_mispred (
        .clk   (clk),
        .rst   (rst),
        .inc   (mp_cnt_inc),
        .count (stat_mispred)
    );
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule
